// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM states, ALUOp/ALUControl codes and the datapath control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // ALUOP_ADD is the all-zero code so idle states default to an add.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
  } ctrl_t;

  function automatic logic is_mem_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus funct field to ALUControl.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUC_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUC_ADD;
      ALUOP_SUB: alucontrol_o = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALUC_ADD;
          FN_SUB:  alucontrol_o = ALUC_SUB;
          FN_AND:  alucontrol_o = ALUC_AND;
          FN_OR:   alucontrol_o = ALUC_OR;
          FN_SLT:  alucontrol_o = ALUC_SLT;
          default: alucontrol_o = ALUC_ADD;
        endcase
      end
      default: alucontrol_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath, with memory handshake
// and a sticky memory-latency timeout flag.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;
  ctrl_t      ctl;
  aluop_e     aluop;
  logic       illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctl       = '0;
    aluop     = ALUOP_ADD;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        ctl.alusrcb = 2'b01;
        ctl.irwrite = mem_ready;
        ctl.pcen    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BRANCH can take it from ALUOut.
        ctl.alusrcb = 2'b11;
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
        state_d     = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_req = 1'b1;
        ctl.iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.memtoreg = 1'b1;
        ctl.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_req  = 1'b1;
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctl.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.regdst   = 1'b1;
        ctl.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        ctl.pcsrc   = 2'b01;
        ctl.pcen    = (opcode == OP_BNE) ? ~zero : zero;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl.regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        ctl.pcsrc = 2'b10;
        ctl.pcen  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Counts only stalled memory cycles; the FSM keeps waiting past the limit.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (is_mem_wait_state(state_q) && !mem_ready)
      wait_cnt_d = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
    mem_timeout_d = mem_timeout_q | (wait_cnt_d >= TIMEOUT_CNT);
  end

  mips_alu_decoder u_alu_dec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (ALUControl)
  );

  // Write enables and the request are gated by reset so an in-flight access
  // is dropped the instant rst_n falls, independent of the clock.
  assign mem_req     = ctl.mem_req  & rst_n;
  assign MemWrite    = ctl.memwrite & rst_n;
  assign IRWrite     = ctl.irwrite  & rst_n;
  assign RegWrite    = ctl.regwrite & rst_n;
  assign PCEn        = ctl.pcen     & rst_n;
  assign IorD        = ctl.iord;
  assign RegDst      = ctl.regdst;
  assign MemtoReg    = ctl.memtoreg;
  assign ALUSrcA     = ctl.alusrca;
  assign ALUSrcB     = ctl.alusrcb;
  assign PCSrc       = ctl.pcsrc;
  assign illegal_op  = illegal_d;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Vector table plus hand-written reset/timeout/illegal sequences for the
// multicycle MIPS control FSM; expectations flow through a scoreboard queue.
module tb_mips_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;

  // st, {req,iord,mw,irw,rdst,m2r,rw,srca}, srcb, aluc, pcsrc, {pcen,ill,tmo}
  typedef struct packed {
    logic [3:0] st;
    logic [7:0] c;
    logic [1:0] srcb;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic [2:0] f;
  } out_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic       z, mr;
    out_t       exp;
    logic       dc;
  } vec_t;

  typedef struct packed { out_t exp; logic dc; } sb_t;

  logic clk, rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic PCEn, illegal_op, mem_timeout;
  logic [3:0] state;

  int n_chk = 0, n_pass = 0;
  vec_t tbl[$];
  sb_t  sb[$];
  out_t F_RDY, F_WAIT, DEC, RST;

  mips_multicycle_control #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .PCEn(PCEn), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic out_t o(input logic [3:0] st, input logic [7:0] c,
                             input logic [1:0] sbv, input logic [2:0] al,
                             input logic [1:0] pc, input logic [2:0] f);
    return {st, c, sbv, al, pc, f};
  endfunction

  function automatic vec_t mk(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic z, input logic mr, input out_t e, input logic dc);
    vec_t v;
    v.name = nm; v.op = op; v.fn = fn; v.z = z; v.mr = mr; v.exp = e; v.dc = dc;
    return v;
  endfunction

  // dc masks ALUControl in states where no ALU operation is specified.
  task automatic check(input string nm, input out_t exp, input logic dc);
    out_t act, m;
    act = {state, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, illegal_op, mem_timeout};
    m = '1;
    if (dc) m.aluc = 3'b000;
    n_chk++;
    if ((act & m) === (exp & m)) n_pass++;
    else $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, m);
  endtask

  // Drive one cycle of inputs; expected outputs go through the scoreboard.
  task automatic step(input vec_t v);
    sb_t e;
    opcode = v.op; funct = v.fn; zero = v.z; mem_ready = v.mr;
    e.exp = v.exp; e.dc = v.dc;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      check(v.name, e.exp, e.dc);
    end
    @(posedge clk); #1;
  endtask

  task automatic async_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 check({nm, ".now"}, RST, 1'b0);
    mem_ready = 1'b1;
    #1 check({nm, ".rdy"}, RST, 1'b0);
    @(posedge clk); #1;
    check({nm, ".edge"}, RST, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    F_RDY  = o(4'd0, 8'b1001_0000, 2'b01, 3'b010, 2'b00, 3'b100);
    F_WAIT = o(4'd0, 8'b1000_0000, 2'b01, 3'b010, 2'b00, 3'b000);
    DEC    = o(4'd1, 8'b0000_0000, 2'b11, 3'b010, 2'b00, 3'b000);
    RST    = o(4'd0, 8'b0000_0000, 2'b01, 3'b010, 2'b00, 3'b000);

    // lw, no wait: 5 cycles
    tbl.push_back(mk("lw.fetch", LW, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    tbl.push_back(mk("lw.dec",   LW, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    tbl.push_back(mk("lw.adr",   LW, 6'd0, 1'b0, 1'b1, o(4'd2, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000), 1'b0));
    tbl.push_back(mk("lw.rd",    LW, 6'd0, 1'b0, 1'b1, o(4'd3, 8'b1100_0000, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    tbl.push_back(mk("lw.wb",    LW, 6'd0, 1'b0, 1'b1, o(4'd4, 8'b0000_0110, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    // lw with one fetch wait and one read wait
    tbl.push_back(mk("lw2.fwait", LW, 6'd0, 1'b0, 1'b0, F_WAIT, 1'b0));
    tbl.push_back(mk("lw2.fetch", LW, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    tbl.push_back(mk("lw2.dec",   LW, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    tbl.push_back(mk("lw2.adr",   LW, 6'd0, 1'b0, 1'b1, o(4'd2, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000), 1'b0));
    tbl.push_back(mk("lw2.rdw",   LW, 6'd0, 1'b0, 1'b0, o(4'd3, 8'b1100_0000, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    tbl.push_back(mk("lw2.rd",    LW, 6'd0, 1'b0, 1'b1, o(4'd3, 8'b1100_0000, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    tbl.push_back(mk("lw2.wb",    LW, 6'd0, 1'b0, 1'b1, o(4'd4, 8'b0000_0110, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    // R-type: sub, slt, and, or, unknown funct
    begin
      logic [5:0] fns [5];
      logic [2:0] alc [5];
      string      nms [5];
      fns = '{6'b100010, 6'b101010, 6'b100100, 6'b100101, 6'b111111};
      alc = '{3'b110, 3'b111, 3'b000, 3'b001, 3'b010};
      nms = '{"sub", "slt", "and", "or", "fnx"};
      for (int i = 0; i < 5; i++) begin
        tbl.push_back(mk({nms[i], ".fetch"}, RT, fns[i], 1'b0, 1'b1, F_RDY, 1'b0));
        tbl.push_back(mk({nms[i], ".dec"},   RT, fns[i], 1'b0, 1'b1, DEC, 1'b0));
        tbl.push_back(mk({nms[i], ".exec"},  RT, fns[i], 1'b0, 1'b1, o(4'd6, 8'b0000_0001, 2'b00, alc[i], 2'b00, 3'b000), 1'b0));
        tbl.push_back(mk({nms[i], ".wb"},    RT, fns[i], 1'b0, 1'b1, o(4'd7, 8'b0000_1010, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
      end
    end
    // branches: beq/bne with zero = 1 and zero = 0
    begin
      logic [5:0] ops [4];
      logic       zs [4];
      logic       pe [4];
      string      nms [4];
      ops = '{BEQ, BNE, BEQ, BNE};
      zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
      pe  = '{1'b1, 1'b0, 1'b0, 1'b1};
      nms = '{"beq1", "bne1", "beq0", "bne0"};
      for (int i = 0; i < 4; i++) begin
        tbl.push_back(mk({nms[i], ".fetch"}, ops[i], 6'd0, zs[i], 1'b1, F_RDY, 1'b0));
        tbl.push_back(mk({nms[i], ".dec"},   ops[i], 6'd0, zs[i], 1'b1, DEC, 1'b0));
        tbl.push_back(mk({nms[i], ".br"},    ops[i], 6'd0, zs[i], 1'b1,
                         o(4'd8, 8'b0000_0001, 2'b00, 3'b110, 2'b01, {pe[i], 2'b00}), 1'b0));
      end
    end
    // j, addi, sw
    tbl.push_back(mk("j.fetch",    JMP, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    tbl.push_back(mk("j.dec",      JMP, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    tbl.push_back(mk("j.jump",     JMP, 6'd0, 1'b0, 1'b1, o(4'd11, 8'b0000_0000, 2'b00, 3'b010, 2'b10, 3'b100), 1'b1));
    tbl.push_back(mk("addi.fetch", ADDI, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    tbl.push_back(mk("addi.dec",   ADDI, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    tbl.push_back(mk("addi.ex",    ADDI, 6'd0, 1'b0, 1'b1, o(4'd9, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000), 1'b0));
    tbl.push_back(mk("addi.wb",    ADDI, 6'd0, 1'b0, 1'b1, o(4'd10, 8'b0000_0010, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    tbl.push_back(mk("sw.fetch",   SW, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    tbl.push_back(mk("sw.dec",     SW, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    tbl.push_back(mk("sw.adr",     SW, 6'd0, 1'b0, 1'b1, o(4'd2, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000), 1'b0));
    tbl.push_back(mk("sw.wr",      SW, 6'd0, 1'b0, 1'b1, o(4'd5, 8'b1110_0000, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));

    // power-on reset, with mem_ready high and ignored
    rst_n = 1'b0; opcode = LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    #1 check("por", RST, 1'b0);
    @(posedge clk); #1;
    check("por.edge", RST, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // reset mid-MEMRD, then first fetch after release
    step(mk("mr.fetch", LW, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    step(mk("mr.dec",   LW, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    step(mk("mr.adr",   LW, 6'd0, 1'b0, 1'b1, o(4'd2, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000), 1'b0));
    step(mk("mr.rdw",   LW, 6'd0, 1'b0, 1'b0, o(4'd3, 8'b1100_0000, 2'b00, 3'b010, 2'b00, 3'b000), 1'b1));
    async_reset("mr.rst");
    step(mk("mr.refetch", JMP, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    step(mk("mr.redec",   JMP, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    step(mk("mr.jump",    JMP, 6'd0, 1'b0, 1'b1, o(4'd11, 8'b0000_0000, 2'b00, 3'b010, 2'b10, 3'b100), 1'b1));

    // sw with 20 wait cycles; timeout sets after the 16th and stays sticky
    step(mk("to.fetch", SW, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    step(mk("to.dec",   SW, 6'd0, 1'b0, 1'b1, DEC, 1'b0));
    step(mk("to.adr",   SW, 6'd0, 1'b0, 1'b1, o(4'd2, 8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000), 1'b0));
    for (int i = 0; i < 20; i++)
      step(mk($sformatf("to.wait%0d", i), SW, 6'd0, 1'b0, 1'b0,
              o(4'd5, 8'b1110_0000, 2'b00, 3'b010, 2'b00, {2'b00, (i >= 16)}), 1'b1));
    step(mk("to.wr",    SW, 6'd0, 1'b0, 1'b1, o(4'd5, 8'b1110_0000, 2'b00, 3'b010, 2'b00, 3'b001), 1'b1));
    step(mk("to.sticky", SW, 6'd0, 1'b0, 1'b1, o(4'd0, 8'b1001_0000, 2'b01, 3'b010, 2'b00, 3'b101), 1'b0));
    async_reset("to.rst");

    // illegal opcode: one-cycle pulse, straight back to FETCH
    step(mk("ill.fetch", BAD, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));
    step(mk("ill.dec",   BAD, 6'd0, 1'b0, 1'b1, o(4'd1, 8'b0000_0000, 2'b11, 3'b010, 2'b00, 3'b010), 1'b0));
    step(mk("ill.after", BAD, 6'd0, 1'b0, 1'b1, F_RDY, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
